// File: rtl/ca_epl_code_gen_if.sv
// Strobe/control inputs and code outputs of the C/A early-prompt-late code generator.
// The master side drives strobes and loads; the slave side is the code generator.
interface ca_epl_code_gen_if;
    logic        hc_enable;
    logic        tic_enable;
    logic        prn_key_enable;
    logic [9:0]  prn_key;
    logic        slew_enable;
    logic [10:0] slew;
    logic        early;
    logic        prompt;
    logic        late;
    logic        dump_enable;
    logic [10:0] code_phase;
    logic [10:0] code_phase_latched;

    modport master (
        output hc_enable, tic_enable, prn_key_enable, prn_key, slew_enable, slew,
        input  early, prompt, late, dump_enable, code_phase, code_phase_latched
    );

    modport slave (
        input  hc_enable, tic_enable, prn_key_enable, prn_key, slew_enable, slew,
        output early, prompt, late, dump_enable, code_phase, code_phase_latched
    );
endinterface

// File: rtl/ca_epl_code_gen.sv
// GPS C/A code generator: early/prompt/late chips at half-chip resolution, slew hold, epoch dump.
// Optional feature macro CA_CODE_PHASE_LATCH_EN: capture code_phase on tic_enable.
module ca_epl_code_gen (
    input  logic             clk,
    input  logic             rstn,
    ca_epl_code_gen_if.slave bus
);
    localparam logic [10:0] LAST_PHASE = 11'd2045;
    localparam logic [9:0]  G1_INIT    = 10'h3FF;

    // Bit k of each LFSR vector is stage 10-k: bit 0 is stage 10 (the output tap)
    // and prn_key loads with its MSB into stage 1.
    logic [9:0]  g1_q, g1_d;
    logic [9:0]  g2_q, g2_d;
    logic [9:0]  key_q, key_d;
    logic [10:0] phase_q, phase_d;
    logic [10:0] slew_cnt_q, slew_cnt_d;
    logic [10:0] latched_q, latched_d;
    logic        toggle_q, toggle_d;
    logic [1:0]  dly_q, dly_d;
    logic        dump_q, dump_d;

    logic early;
    logic g1_fb;
    logic g2_fb;

    assign early = g1_q[0] ^ g2_q[0];
    assign g1_fb = g1_q[7] ^ g1_q[0];
    assign g2_fb = g2_q[8] ^ g2_q[7] ^ g2_q[4] ^ g2_q[2] ^ g2_q[1] ^ g2_q[0];

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
        g1_d       = g1_q;
        g2_d       = g2_q;
        key_d      = key_q;
        phase_d    = phase_q;
        slew_cnt_d = slew_cnt_q;
        toggle_d   = toggle_q;
        dly_d      = dly_q;
        dump_d     = 1'b0;

        if (bus.prn_key_enable) begin
            key_d    = bus.prn_key;
            g1_d     = G1_INIT;
            g2_d     = bus.prn_key;
            phase_d  = '0;
            toggle_d = 1'b0;
            dly_d    = '0;
        end else if (bus.slew_enable) begin
            slew_cnt_d = bus.slew;
        end else if (bus.hc_enable) begin
            if (slew_cnt_q != '0) begin
                // Held half-chip: only the slew counter moves.
                slew_cnt_d = slew_cnt_q - 11'd1;
                dump_d     = (slew_cnt_q == 11'd1);
            end else begin
                toggle_d = ~toggle_q;
                dly_d    = {dly_q[0], early};
                if (phase_q == LAST_PHASE) begin
                    phase_d = '0;
                    g1_d    = G1_INIT;
                    g2_d    = key_q;
                    dump_d  = 1'b1;
                end else begin
                    phase_d = phase_q + 11'd1;
                    if (toggle_q) begin
                        g1_d = {g1_fb, g1_q[9:1]};
                        g2_d = {g2_fb, g2_q[9:1]};
                    end
                end
            end
        end
    end

`ifdef CA_CODE_PHASE_LATCH_EN
    always_comb begin
        latched_d = latched_q;
        if (bus.tic_enable) begin
            latched_d = phase_q;
        end
    end
`else
    logic tic_unused;
    assign tic_unused = bus.tic_enable;
    assign latched_d  = '0;
`endif

    // NOTE: state flops use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            g1_q       <= G1_INIT;
            g2_q       <= '0;
            key_q      <= '0;
            phase_q    <= '0;
            slew_cnt_q <= '0;
            latched_q  <= '0;
            toggle_q   <= 1'b0;
            dly_q      <= '0;
            dump_q     <= 1'b0;
        end else begin
            g1_q       <= g1_d;
            g2_q       <= g2_d;
            key_q      <= key_d;
            phase_q    <= phase_d;
            slew_cnt_q <= slew_cnt_d;
            latched_q  <= latched_d;
            toggle_q   <= toggle_d;
            dly_q      <= dly_d;
            dump_q     <= dump_d;
        end
    end

    assign bus.early              = early;
    assign bus.prompt             = dly_q[0];
    assign bus.late               = dly_q[1];
    assign bus.dump_enable        = dump_q;
    assign bus.code_phase         = phase_q;
    assign bus.code_phase_latched = latched_q;
endmodule

// File: tb/tb_ca_epl_code_gen.sv
// Self-checking bench for ca_epl_code_gen: PRN1 vector table, directed corner sequences and
// randomized traffic, all checked against a chip-table reference model built from code recurrences.
module tb_ca_epl_code_gen;
    logic clk;
    logic rstn;

    ca_epl_code_gen_if bus_if ();

    ca_epl_code_gen dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

`ifdef CA_CODE_PHASE_LATCH_EN
    localparam bit LATCH_EN = 1'b1;
`else
    localparam bit LATCH_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: one 1023-chip table per key, a half-chip index, a slew count.
    bit ca_chips [0:1022];
    int m_phase;
    int m_nacc;
    int m_slew;
    int m_lat;
    bit m_dump;

    // Output-sequence recurrences of the two LFSRs; the first 10 outputs are the initial stages.
    task automatic build_code(input logic [9:0] key);
        bit a [0:1032];
        bit b [0:1032];
        for (int n = 0; n < 10; n++) begin
            a[n] = 1'b1;
            b[n] = key[n];
        end
        for (int n = 0; n < 1023; n++) begin
            a[n+10] = a[n+7] ^ a[n];
            b[n+10] = b[n+8] ^ b[n+7] ^ b[n+4] ^ b[n+2] ^ b[n+1] ^ b[n];
        end
        for (int n = 0; n < 1023; n++) ca_chips[n] = a[n] ^ b[n];
    endtask

    task automatic model_reset();
        build_code(10'h000);
        m_phase = 0;
        m_nacc  = 0;
        m_slew  = 0;
        m_lat   = 0;
        m_dump  = 1'b0;
    endtask

    task automatic model_step(input logic hc, input logic tic, input logic pk, input logic [9:0] key,
                              input logic sl, input logic [10:0] s);
        int p_before;
        p_before = m_phase;
        m_dump   = 1'b0;
        if (pk) begin
            build_code(key);
            m_phase = 0;
            m_nacc  = 0;
        end else if (sl) begin
            m_slew = int'(s);
        end else if (hc) begin
            if (m_slew > 0) begin
                m_slew--;
                m_dump = (m_slew == 0);
            end else begin
                m_dump  = (m_phase == 2045);
                m_phase = (m_phase + 1) % 2046;
                m_nacc++;
            end
        end
        if (tic && LATCH_EN) m_lat = p_before;
    endtask

    function automatic logic [31:0] model_outs();
        logic e, p, l;
        e = ca_chips[m_phase / 2];
        p = (m_nacc >= 1) ? ca_chips[((m_phase + 2045) % 2046) / 2] : 1'b0;
        l = (m_nacc >= 2) ? ca_chips[((m_phase + 2044) % 2046) / 2] : 1'b0;
        return {6'd0, e, p, l, m_dump, 11'(m_phase), 11'(m_lat)};
    endfunction

    function automatic logic [31:0] dut_outs();
        return {6'd0, bus_if.early, bus_if.prompt, bus_if.late, bus_if.dump_enable,
                bus_if.code_phase, bus_if.code_phase_latched};
    endfunction

    // One clock: drive at edge+1, model steps on the edge, outputs compared at the next edge+1.
    task automatic tick(input logic hc, input logic tic, input logic pk, input logic [9:0] key,
                        input logic sl, input logic [10:0] s);
        bus_if.hc_enable      = hc;
        bus_if.tic_enable     = tic;
        bus_if.prn_key_enable = pk;
        bus_if.prn_key        = key;
        bus_if.slew_enable    = sl;
        bus_if.slew           = s;
        @(posedge clk);
        model_step(hc, tic, pk, key, sl, s);
        #1;
        bus_if.hc_enable      = 1'b0;
        bus_if.tic_enable     = 1'b0;
        bus_if.prn_key_enable = 1'b0;
        bus_if.slew_enable    = 1'b0;
        cyc++;
        check($sformatf("model_cyc%0d", cyc), dut_outs(), model_outs());
    endtask

    task automatic idle();                     tick(1'b0, 1'b0, 1'b0, 10'h0, 1'b0, 11'd0); endtask
    task automatic hc();                       tick(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 11'd0); endtask
    task automatic load_key(input logic [9:0] k);  tick(1'b0, 1'b0, 1'b1, k, 1'b0, 11'd0); endtask
    task automatic load_slew(input logic [10:0] s); tick(1'b0, 1'b0, 1'b0, 10'h0, 1'b1, s); endtask

    typedef struct packed {
        logic        hc;
        logic        exp_early;
        logic [10:0] exp_phase;
    } vec_t;

    vec_t pn1_vec [20];
    bit   first_epoch [0:2045];
    bit   hist [$];

    initial begin
        logic [9:0]  pat;
        logic [10:0] p0;
        logic        e0;
        int          dcount;

        pat = 10'o1440;
        for (int i = 0; i < 20; i++) begin
            pn1_vec[i].hc        = 1'b1;
            pn1_vec[i].exp_early = pat[9 - i/2];
            pn1_vec[i].exp_phase = 11'(i);
        end

        bus_if.hc_enable      = 1'b0;
        bus_if.tic_enable     = 1'b0;
        bus_if.prn_key_enable = 1'b0;
        bus_if.prn_key        = 10'h0;
        bus_if.slew_enable    = 1'b0;
        bus_if.slew           = 11'd0;

        // Reset state
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_outs", dut_outs(), {6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0});
        rstn = 1'b1;
        idle();

        // PRN1 first ten chips, each held for two half-chips
        load_key(10'h3EC);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("pn1_early_%0d", i), 32'(bus_if.early), 32'(pn1_vec[i].exp_early));
            check($sformatf("pn1_phase_%0d", i), 32'(bus_if.code_phase), 32'(pn1_vec[i].exp_phase));
            tick(pn1_vec[i].hc, 1'b0, 1'b0, 10'h0, 1'b0, 11'd0);
        end

        // Full epoch with a strobe every 12 clocks, then check the code repeats
        load_key(10'h3EC);
        dcount = 0;
        for (int s = 0; s < 2046; s++) begin
            first_epoch[s] = bus_if.early;
            hc();
            if (bus_if.dump_enable) dcount++;
            if (s == 2045) begin
                check("wrap_dump", 32'(bus_if.dump_enable), 32'd1);
                check("wrap_phase", 32'(bus_if.code_phase), 32'd0);
            end
            for (int j = 0; j < 11; j++) begin
                idle();
                if (bus_if.dump_enable) dcount++;
            end
        end
        check("epoch_dump_count", 32'(dcount), 32'd1);
        for (int k = 0; k < 100; k++) begin
            check($sformatf("repeat_%0d", k), 32'(bus_if.early), 32'(first_epoch[k]));
            hc();
        end

        // Slew of 5 half-chips mid-code
        p0 = bus_if.code_phase;
        e0 = bus_if.early;
        load_slew(11'd5);
        check("slew_load_phase", 32'(bus_if.code_phase), 32'(p0));
        for (int k = 1; k <= 5; k++) begin
            hc();
            check($sformatf("slew_hold_phase_%0d", k), 32'(bus_if.code_phase), 32'(p0));
            check($sformatf("slew_hold_early_%0d", k), 32'(bus_if.early), 32'(e0));
            check($sformatf("slew_dump_%0d", k), 32'(bus_if.dump_enable), (k == 5) ? 32'd1 : 32'd0);
        end
        hc();
        check("slew_resume_phase", 32'(bus_if.code_phase), 32'(p0) + 32'd1);

        // prn_key_enable beats hc_enable; toggle restarts at 0
        hc();
        tick(1'b1, 1'b0, 1'b1, 10'h001, 1'b0, 11'd0);
        check("pk_hc_phase", 32'(bus_if.code_phase), 32'd0);
        check("pk_hc_early", 32'(bus_if.early), 32'd0);
        hc();
        check("pk_toggle_hold", 32'(bus_if.early), 32'd0);
        hc();
        check("pk_toggle_shift", 32'(bus_if.early), 32'd1);
        // slew_enable beats hc_enable; overwrite and cancel
        tick(1'b1, 1'b0, 1'b0, 10'h0, 1'b1, 11'd2);
        check("sl_hc_phase", 32'(bus_if.code_phase), 32'd2);
        hc();
        check("sl_hold_phase", 32'(bus_if.code_phase), 32'd2);
        load_slew(11'd0);
        hc();
        check("sl_cancel_phase", 32'(bus_if.code_phase), 32'd3);
        check("sl_cancel_nodump", 32'(bus_if.dump_enable), 32'd0);
        load_slew(11'd3);
        hc();
        load_slew(11'd1);
        hc();
        check("sl_overwrite_dump", 32'(bus_if.dump_enable), 32'd1);
        check("sl_overwrite_phase", 32'(bus_if.code_phase), 32'd3);

        // prompt/late follow early by one and two accepted half-chips
        load_key(10'h2C7);
        hist = {1'b0, 1'b0};
        for (int i = 0; i < 100; i++) begin
            hist.push_back(bus_if.early);
            hc();
            check($sformatf("prompt_%0d", i), 32'(bus_if.prompt), 32'(hist[$]));
            check($sformatf("late_%0d", i), 32'(bus_if.late), 32'(hist[$-1]));
        end

        // TIC capture at code_phase 700, coincident with an accepted half-chip
        load_key(10'h3EC);
        for (int i = 0; i < 700; i++) hc();
        tick(1'b1, 1'b1, 1'b0, 10'h0, 1'b0, 11'd0);
        check("tic_latched", 32'(bus_if.code_phase_latched), LATCH_EN ? 32'd700 : 32'd0);
        check("tic_phase", 32'(bus_if.code_phase), 32'd701);

        // Reset pulse in the middle of a slew
        load_slew(11'd10);
        for (int i = 0; i < 3; i++) hc();
        rstn = 1'b0;
        #2;
        check("midrst_outs", dut_outs(), {6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0});
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle();
        hc();
        check("midrst_first_hc_nodump", 32'(bus_if.dump_enable), 32'd0);
        check("midrst_slew_aborted", 32'(bus_if.code_phase), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 199) == 0),
                 10'($urandom),
                 1'($urandom_range(0, 63) == 0),
                 11'($urandom_range(0, 6)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ca_epl_code_gen.md
CA_EPL_CODE_GEN -- requirements
Module: ca_epl_code_gen

Interface
REQ-001 SHALL have port: clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-002 SHALL have port: rstn  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: hc_enable  input  1  one-cycle half-chip strobe from the code NCO.
REQ-004 SHALL have port: tic_enable  input  1  one-cycle TIC strobe.
REQ-005 SHALL have port: prn_key_enable  input  1  one-cycle load strobe for prn_key.
REQ-006 SHALL have port: prn_key  input  10  G2 initial state selecting the satellite PRN.
REQ-007 SHALL have port: slew_enable  input  1  one-cycle load strobe for slew.
REQ-008 SHALL have port: slew  input  11  number of half-chips to hold the code (0..2047).
REQ-009 SHALL have port: early  output  1  early code chip.
REQ-010 SHALL have port: prompt  output  1  prompt code chip (early delayed 1 half-chip).
REQ-011 SHALL have port: late  output  1  late code chip (early delayed 2 half-chips).
REQ-012 SHALL have port: dump_enable  output  1  one-cycle accumulator dump strobe.
REQ-013 SHALL have port: code_phase  output  11  current half-chip index 0..2045.
REQ-014 SHALL have port: code_phase_latched  output  11  code_phase captured at TIC (see Configuration).

Function
REQ-015 SHALL implement G1 as a 10-bit LFSR, feedback = G1[3]^G1[10], init 10'h3FF.
REQ-016 SHALL implement G2 as a 10-bit LFSR, feedback = G2[2]^G2[3]^G2[6]^G2[8]^G2[9]^G2[10], init = stored prn_key.
REQ-017 SHALL drive early = G1[10]^G2[10] (combinational from the registered LFSR state).
REQ-018 SHALL keep a 1-bit half-chip phase toggle; each accepted hc_enable toggles it; G1/G2 shift only on accepted hc_enable with toggle=1.
REQ-019 SHALL shift a 2-bit delay line on every accepted hc_enable: prompt <= early, late <= prompt.
REQ-020 SHALL increment code_phase on each accepted hc_enable; at 2045 it wraps to 0 and both LFSRs reload to their init values in the same cycle.
REQ-021 SHALL assert dump_enable for exactly one cycle, the cycle after the hc_enable that wraps code_phase 2045->0.
REQ-022 SHALL load slew_cnt <= slew on slew_enable; while slew_cnt != 0, each hc_enable decrements slew_cnt and is not accepted (LFSRs, toggle, delay line and code_phase hold).
REQ-023 SHALL assert dump_enable for one cycle after the hc_enable that decrements slew_cnt 1->0.
REQ-024 SHALL, on prn_key_enable, store prn_key, set G1=10'h3FF, G2=prn_key, code_phase=0, toggle=0, delay line=0; slew_cnt unchanged; no dump_enable.
REQ-025 SHALL give priority prn_key_enable > slew_enable > hc_enable when asserted in the same cycle; the lower-priority hc_enable is dropped.
REQ-026 SHALL let a slew_enable during a pending slew overwrite slew_cnt; slew = 0 cancels the hold without a dump_enable.

Reset
REQ-027 SHALL, while rstn=0, force G1=10'h3FF, G2=0, stored key=0, code_phase=0, toggle=0, delay line=0, slew_cnt=0, dump_enable=0, code_phase_latched=0.
REQ-028 SHALL abort any pending slew or epoch on mid-operation reset; the first accepted hc_enable after release produces no dump_enable.

Configuration
REQ-029 SHALL, with macro CA_CODE_PHASE_LATCH_EN defined, update code_phase_latched <= code_phase on each tic_enable (the value before any same-cycle update).
REQ-030 SHALL, without CA_CODE_PHASE_LATCH_EN, tie code_phase_latched to 0 and ignore tic_enable.

Verification
REQ-031 SHALL cover: reset, then prn_key=10'h3EC, prn_key_enable, 20 hc_enable -> early chips 1,1,0,0,1,0,0,0,0,0 (PRN1 octal 1440), each held 2 half-chips.
REQ-032 SHALL cover: continuous hc_enable every 12 clk for 2046 strobes -> dump_enable one pulse after strobe 2046, code_phase=0, early sequence repeats identically.
REQ-033 SHALL cover: slew=5, slew_enable mid-code -> code_phase frozen for 5 hc_enable, dump_enable after the 5th, code resumes at the prior chip.
REQ-034 SHALL cover: prn_key_enable and hc_enable in the same cycle -> code_phase=0, toggle=0, hc_enable dropped; slew_enable and hc_enable together -> slew loaded, code_phase unchanged.
REQ-035 SHALL cover: prompt equals early delayed exactly one accepted hc_enable and late two, checked over 100 half-chips.
REQ-036 SHALL cover: with CA_CODE_PHASE_LATCH_EN, tic_enable at code_phase=700 -> code_phase_latched=700; without it -> 0; rstn pulse mid-slew -> all outputs reset, no dump_enable.
